// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and sizing helpers for the SPI mode-0 slave transceiver
package spi_slave_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest width able to hold the value n (clog2(n+1)), never below one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < (n + 1)) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-stage flip-flop synchronizer for one asynchronous input bit
module sync_bit #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_xcvr.sv
// rtl/spi_slave_xcvr.sv - SPI mode-0 slave transceiver with one-entry tx holding register
// Bit order is MSB first; defining SPI_SLAVE_LSB_FIRST_EN makes both directions LSB first.
module spi_slave_xcvr
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = 'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = cnt_width(DATA_W);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int TX_BIT = 0;
`else
    localparam int TX_BIT = DATA_W - 1;
`endif

    logic sclk_s, csn_s, mosi_s;
    logic sclk_prev_q, csn_prev_q;
    logic sclk_rise, sclk_fall, csn_fall;

    sync_bit #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(spi_sclk), .q_o(sclk_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .d_i(spi_csn), .q_o(csn_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s)
    );

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic              started_q, started_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_shifted;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_next;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              load, hold_wr;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_shift_q[DATA_W-1:1]};
    assign tx_shifted = {1'b0, tx_shift_q[DATA_W-1:1]};
`else
    assign rx_next    = {rx_shift_q[DATA_W-2:0], mosi_s};
    assign tx_shifted = {tx_shift_q[DATA_W-2:0], 1'b0};
`endif

    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
    assign hold_wr     = tx_valid & ~hold_full_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        started_d  = started_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_d    = ST_SHIFT;
                    load       = 1'b1;
                    bit_cnt_d  = '0;
                    started_d  = 1'b0;
                    rx_shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (csn_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    started_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    started_d  = 1'b1;
                    if (bit_cnt_inc == CNT_W'(DATA_W)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shifted;
                    end else if (started_q) begin
                        // Word boundary inside a frame: next word must be on MISO before the next rise.
                        load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end

        hold_d      = hold_wr ? tx_data : hold_q;
        hold_full_d = hold_wr | (hold_full_q & ~load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            started_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            started_q   <= started_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign spi_miso_oe = (state_q == ST_SHIFT);
    assign spi_miso    = (state_q == ST_SHIFT) ? tx_shift_q[TX_BIT] : 1'b1;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = ~csn_s;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// tb/tb_spi_slave_xcvr.sv - randomized self-checking bench for spi_slave_xcvr against a word-level model
module tb_spi_slave_xcvr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] feed_q[$];
    logic [7:0] rx_got[$];
    int         ur_total = 0;
    logic [7:0] mosi_w[4];
    logic [7:0] tx_w[4];

    spi_slave_xcvr dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Position of the b-th transmitted bit inside a word.
    function automatic int bitpos(input int b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return b;
`else
        return 7 - b;
`endif
    endfunction

    always @(negedge clk) begin
        if (rx_valid) rx_got.push_back(rx_data);
        if (tx_underrun) ur_total++;
    end

    // Presents queued tx words one at a time, popping on handshake.
    initial begin
        bit acc;
        acc = 1'b0;
        forever begin
            @(negedge clk);
            if (acc) void'(feed_q.pop_front());
            tx_valid = (feed_q.size() > 0);
            tx_data  = tx_valid ? feed_q[0] : 8'h00;
            acc      = tx_valid && tx_ready;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, spi_miso, 1);
        check({tag, "_oe"}, spi_miso_oe, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_underrun"}, tx_underrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One csn frame of nbits; rst_bit >= 0 aborts it with a reset at that bit.
    task automatic frame(input int nbits, input int ntx, input int rst_bit);
        logic [7:0] got[4];
        logic [7:0] expw, msk;
        int nw, w, p, rx_base, ur_base;
        for (int i = 0; i < ntx; i++) feed_q.push_back(tx_w[i]);
        repeat (6) @(negedge clk);
        rx_base = rx_got.size();
        ur_base = ur_total;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;
        spi_csn = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            w = i / 8;
            p = bitpos(i % 8);
            spi_mosi = mosi_w[w][p];
            repeat (5) @(negedge clk);
            if (i == 0) begin
                check("busy_in_frame", busy, 1);
                check("oe_in_frame", spi_miso_oe, 1);
            end
            if (i == rst_bit) begin
                rst = 1'b1;
                spi_csn = 1'b1;
                spi_sclk = 1'b0;
                spi_mosi = 1'b0;
                @(negedge clk);
                check_reset_outputs("midrst");
                rst = 1'b0;
                repeat (6) @(negedge clk);
                return;
            end
            spi_sclk = 1'b1;
            got[w][p] = spi_miso;
            repeat (5) @(negedge clk);
            if (i != nbits - 1) spi_sclk = 1'b0;
        end
        spi_csn = 1'b1;
        repeat (2) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (10) @(negedge clk);
        check("oe_after_frame", spi_miso_oe, 0);
        check("miso_after_frame", spi_miso, 1);
        nw = (nbits + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            expw = (i < ntx) ? tx_w[i] : 8'hFF;
            msk = 8'h00;
            for (int b = 0; b < 8 && (8 * i + b) < nbits; b++) msk[bitpos(b)] = 1'b1;
            check("miso_word", got[i], expw & msk);
        end
        check("rx_count", rx_got.size() - rx_base, nbits / 8);
        for (int i = 0; i < nbits / 8 && rx_base + i < rx_got.size(); i++)
            check("rx_word", rx_got[rx_base + i], mosi_w[i]);
        check("underruns", ur_total - ur_base, nw - ntx);
        check("tx_ready_idle", tx_ready, 1);
    endtask

    initial begin
        int k, ntx;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        mosi_w[0] = 8'h3C; tx_w[0] = 8'hA5;
        frame(8, 1, -1);
        mosi_w[0] = 8'h41;
        frame(8, 0, -1);
        mosi_w[0] = 8'h5A; mosi_w[1] = 8'hC3; tx_w[0] = 8'h11; tx_w[1] = 8'h22;
        frame(16, 2, -1);
        mosi_w[0] = 8'hF0; tx_w[0] = 8'h96;
        frame(5, 1, -1);
        mosi_w[0] = 8'h0F; tx_w[0] = 8'h69;
        frame(8, 1, -1);
        mosi_w[0] = 8'hAA;
        frame(8, 0, 4);
        mosi_w[0] = 8'h7E; tx_w[0] = 8'hB4;
        frame(8, 1, -1);
        mosi_w[0] = 8'h80; tx_w[0] = 8'h01;
        frame(8, 1, -1);

        for (int f = 0; f < 10; f++) begin
            k = $urandom_range(1, 3);
            ntx = $urandom_range(0, k);
            for (int i = 0; i < 4; i++) begin
                mosi_w[i] = 8'($urandom);
                tx_w[i]   = 8'($urandom);
            end
            frame(8 * k, ntx, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
